up5bit_counter_sched: RTL
=========================

Name: up5bit_counter_sched

Overview:
- Round-robin scheduler that shares one 5-bit up counter datapath among NREQ requesters.
- Each granted requester gets one counting run from 0 up to its own terminal value.
- The block raises `done` when the run finishes, then re-arbitrates.
- Sits in front of the up-counter testcase family, in the same style as the other small-design tests: the same golden-vs-post-route comparison bench applies.

Parameters:
- WIDTH, 5, counter and terminal-value width in bits
- NREQ, 4, number of requesters (2..8)

Ports:
- clk  input  1  single clock, all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  NREQ  per-requester request level
- tgt_flat  input  NREQ*WIDTH  packed terminal values; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, held for the whole run including the DONE cycle
- out  output  WIDTH  shared counter value
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse marking the final cycle of a run

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values: state=IDLE, out=0, gnt=0, busy=0, done=0, round-robin pointer rr=0 (req[0] has highest priority).
- State machine (registered outputs): IDLE, RUN, DONE.
- IDLE:
  - If |req at an edge, select the winner: the first set bit of req searching from index rr upward, wrapping modulo NREQ.
  - On that edge: gnt=onehot(winner), tgt_q=winner's tgt slice, out=0, busy=1, state=RUN.
  - Grant latency: gnt is high from the edge that samples req; no idle cycle.
  - If req==0: remain in IDLE; out holds its last value.
- RUN:
  - If out==tgt_q: state=DONE, done=1, out holds.
  - Otherwise out=out+1.
  - Run length: out presents 0,1,...,tgt_q, one value per cycle (tgt_q+1 RUN cycles), then one DONE cycle with out=tgt_q.
- DONE (one cycle):
  - On exit: done=0, gnt=0, busy=0, rr=(winner+1) mod NREQ, state=IDLE.
  - out keeps tgt_q until the next grant.
- Minimum spacing: one IDLE cycle between consecutive runs.
- Arithmetic: out never exceeds tgt_q, so it never wraps.
  - tgt=31 (max for WIDTH=5) counts 0..31 with no wrap.
  - tgt=0 gives a single RUN cycle at out=0, then DONE.
- tgt_q is sampled only at grant; tgt_flat changes during a run are ignored.
- req deassertion by the owner during RUN/DONE is ignored; the run completes.
- req edges from other requesters are only evaluated in IDLE.
- Simultaneous requests: only rr-relative priority decides; the previous owner becomes lowest priority.
- Reset asserted mid-run: all outputs go to reset values asynchronously, rr=0.
  - After deassertion, the block restarts from IDLE at the next edge.
- No X propagation: gnt is always zero or one-hot; done is never high outside DONE.

Optional Feature:
- Macro: UP5BIT_SCHED_PAUSE_EN.
- When defined:
  - Extra input `pause` (1 bit) is added after req.
  - While pause=1 in RUN, out, state and gnt freeze.
  - pause is ignored in IDLE and DONE.
  - A paused run resumes at the same value.
  - Reset overrides pause.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset then req=4'b0001, tgt0=5:
  - gnt=0001 from the first sampled edge.
  - out=0,1,2,3,4,5 on successive cycles.
  - done=1 for exactly one cycle with out=5.
  - gnt=0 and busy=0 the next cycle.
- req=4'b1111 held, all tgt=2:
  - Grants in order 0001,0010,0100,1000,0001.
  - Each run shows out=0,1,2 plus a DONE cycle; one IDLE cycle between runs.
- tgt=0 and tgt=31 on requester 2 alone:
  - tgt=0: one RUN cycle at out=0, then done.
  - tgt=31: 32 RUN cycles reaching out=31, no wrap to 0, then done.
- During a run for requester 1 (tgt=10):
  - Change its tgt slice to 3 and drop req[1] at out=4.
  - Run continues to out=10, done pulses, no early termination.
- Assert reset asynchronously (off-edge) at out=7 of a tgt=20 run:
  - out, gnt, busy and done go to 0 immediately.
  - After release with req=4'b1010, requester 1 wins (rr reset to 0).
- Macro defined, tgt=6, pause=1 for 3 cycles at out=3:
  - out holds 3 for those cycles, then continues 4,5,6 and done.
  - Total RUN cycles = 7+3.

Source files
------------

// File: rtl/up5bit_counter_sched.sv
// up5bit_counter_sched: round-robin scheduler sharing one up counter among NREQ requesters.
// Defining UP5BIT_SCHED_PAUSE_EN adds a pause input that freezes a run in progress.
module up5bit_counter_sched #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
`ifdef UP5BIT_SCHED_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic [NREQ*WIDTH-1:0] tgt_flat,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      out,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    rr, rr_n;
    logic [IW-1:0]    owner, owner_n;
    logic [IW-1:0]    win;
    logic             found;
    logic [WIDTH-1:0] tgt_q, tgt_n;
    logic [WIDTH-1:0] out_n;
    logic [NREQ-1:0]  gnt_n;
    logic             busy_n, done_n;
    logic             hold;

`ifdef UP5BIT_SCHED_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // First requester at or after rr, wrapping; the previous owner ends up last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(rr) + k) % NREQ]) begin
                found = 1'b1;
                win   = IW'((int'(rr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_n = state;
        rr_n    = rr;
        owner_n = owner;
        tgt_n   = tgt_q;
        out_n   = out;
        gnt_n   = gnt;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n   = NREQ'(1) << win;
                    tgt_n   = tgt_flat[int'(win)*WIDTH +: WIDTH];
                    owner_n = win;
                    out_n   = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (out == tgt_q) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        out_n = out + 1'b1;
                    end
                end
            end
            DONE: begin
                gnt_n   = '0;
                busy_n  = 1'b0;
                rr_n    = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr    <= '0;
            owner <= '0;
            tgt_q <= '0;
            out   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rr    <= rr_n;
            owner <= owner_n;
            tgt_q <= tgt_n;
            out   <= out_n;
            gnt   <= gnt_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule
